// File: rtl/control_alu_dmem.sv
// control_alu_dmem: MIPS-subset decode, ALU with operand muxing, and word-addressed data RAM
module control_alu_dmem #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        pck,
   input  logic        irq,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [2:0]  pcsrc,
   output logic [1:0]  regdst,
   output logic [1:0]  memtoreg,
   output logic        regwrite,
   output logic [31:0] alu_out,
   output logic        branch_tkn,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_rdata
);
   logic [5:0]  op, fn;
   logic [15:0] imm;
   logic        is_r, r_ok, is_jr, is_shift, is_br, is_lw, is_sw, is_lui, is_j, is_jal, is_imm;
   logic        irq_take, exc, trap, ld, st, in_ram;
   logic [31:0] a, b;
   logic [7:0]  idx;
   logic [31:0] mem_q [MEM_WORDS];
   logic [31:0] mem_d [MEM_WORDS];

   assign op  = instr[31:26];
   assign fn  = instr[5:0];
   assign imm = instr[15:0];

   // Instruction class decode, trap arbitration and control-signal generation
   always_comb begin
      is_r     = op == 6'h00;
      r_ok     = is_r && (fn[5:3] == 3'b100 || fn inside {6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h08, 6'h09});
      is_jr    = is_r && fn[5:1] == 5'b00100;
      is_shift = is_r && fn inside {6'h00, 6'h02, 6'h03};
      is_br    = op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
      is_lw    = op == 6'h23;
      is_sw    = op == 6'h2B;
      is_lui   = op == 6'h0F;
      is_j     = op == 6'h02;
      is_jal   = op == 6'h03;
      is_imm   = op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C};
      irq_take = irq & ~pck;
      exc      = ~irq_take & ~(r_ok | is_lw | is_sw | is_lui | is_imm | is_br | is_j | is_jal);
      trap     = irq_take | exc;
      pcsrc    = irq_take ? 3'b100 : exc ? 3'b101 : is_br ? 3'b001 :
                 (is_j | is_jal) ? 3'b010 : is_jr ? 3'b011 : 3'b000;
      regdst   = trap ? 2'b11 : is_jal ? 2'b10 : (is_lw | is_lui | is_imm) ? 2'b01 : 2'b00;
      memtoreg = (trap | is_jal | (is_jr & fn[0])) ? 2'b10 : is_lw ? 2'b01 : 2'b00;
      regwrite = trap | (is_r & ~(is_jr & ~fn[0])) | is_lw | is_lui | is_imm | is_jal;
      a        = is_shift ? {27'b0, instr[10:6]} : rs_data;
      b        = (is_r | is_br) ? rt_data : is_lui ? {imm, 16'h0} :
                 op == 6'h0C ? {16'h0, imm} : {{16{imm[15]}}, imm};
   end

   // ALU; branch comparisons land in bit 0 with upper bits zero
   always_comb begin
      alu_out = a + b;
      if (is_r)
         case (fn)
            6'h22, 6'h23: alu_out = a - b;
            6'h24:        alu_out = a & b;
            6'h25:        alu_out = a | b;
            6'h26:        alu_out = a ^ b;
            6'h27:        alu_out = ~(a | b);
            6'h00:        alu_out = b << a[4:0];
            6'h02:        alu_out = b >> a[4:0];
            6'h03:        alu_out = $signed(b) >>> a[4:0];
            6'h2A:        alu_out = {31'b0, $signed(a) < $signed(b)};
            6'h2B:        alu_out = {31'b0, a < b};
            default:      alu_out = a + b;
         endcase
      else
         case (op)
            6'h0C:   alu_out = a & b;
            6'h0F:   alu_out = b;
            6'h0A:   alu_out = {31'b0, $signed(a) < $signed(b)};
            6'h0B:   alu_out = {31'b0, a < b};
            6'h04:   alu_out = {31'b0, a == b};
            6'h05:   alu_out = {31'b0, a != b};
            6'h06:   alu_out = {31'b0, $signed(a) <= 32'sd0};
            6'h07:   alu_out = {31'b0, $signed(a) > 32'sd0};
            6'h01:   alu_out = {31'b0, $signed(a) < 32'sd0};
            default: alu_out = a + b;
         endcase
   end

   // Memory routing: bit 30 selects peripheral space, otherwise the local RAM
   always_comb begin
      branch_tkn = alu_out[0];
      idx        = alu_out[9:2];
      in_ram     = ~alu_out[30] && int'(idx) < MEM_WORDS;
      ld         = is_lw & ~trap;
      st         = is_sw & ~trap;
      mem_rd     = ld & alu_out[30];
      mem_wr     = st & alu_out[30];
      mem_rdata  = (ld & in_ram) ? mem_q[idx] : 32'h0;
      mem_d      = mem_q;
      if (st & in_ram) mem_d[idx] = rt_data;
   end

   // RAM state: cleared while reset is low, otherwise takes the pending store
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 32'h0;
      else mem_q <= mem_d;
   end
endmodule

// File: tb/tb_control_alu_dmem.sv
// tb_control_alu_dmem: directed and randomized checks against an instruction-level reference model
module tb_control_alu_dmem;
   logic        clk = 1'b0, reset = 1'b0, pck = 1'b0, irq = 1'b0;
   logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
   logic [2:0]  pcsrc;
   logic [1:0]  regdst, memtoreg;
   logic        regwrite, branch_tkn, mem_rd, mem_wr;
   logic [31:0] alu_out, mem_rdata;
   int          checks = 0, errors = 0;
   logic [31:0] ref_mem [256];
   logic [2:0]  e_pc;
   logic [1:0]  e_rd, e_mtr;
   logic        e_rw, e_aluv, e_ld, e_st;
   logic [31:0] e_alu;
   logic [5:0]  r_fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h08, 6'h09};
   logic [5:0]  i_ops [15] = '{6'h23, 6'h2B, 6'h0F, 6'h08, 6'h09, 6'h0C, 6'h0A, 6'h0B,
                              6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03};

   control_alu_dmem dut (
      .clk(clk), .reset(reset), .instr(instr), .pck(pck), .irq(irq),
      .rs_data(rs_data), .rt_data(rt_data), .pcsrc(pcsrc), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alu_out(alu_out), .branch_tkn(branch_tkn),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rt_i(input logic [5:0] fn, input logic [4:0] sh);
      return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
   endfunction

   function automatic logic [31:0] it_i(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd1, 5'd2, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Per-mnemonic expectations: what each instruction writes, where, and what it computes
   task automatic model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input logic pk, input logic iq);
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [31:0] se, ze;
      bit          known;
      op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
      se = {{16{ins[15]}}, ins[15:0]}; ze = {16'h0, ins[15:0]};
      e_pc = 3'd0; e_rd = 2'd0; e_mtr = 2'd0; e_rw = 1'b0; e_alu = '0;
      e_aluv = 1'b1; e_ld = 1'b0; e_st = 1'b0; known = 1'b1;
      if (op == 6'h00) begin
         e_rw = 1'b1;
         case (fn)
            6'h20, 6'h21: e_alu = rs + rt;
            6'h22, 6'h23: e_alu = rs - rt;
            6'h24: e_alu = rs & rt;
            6'h25: e_alu = rs | rt;
            6'h26: e_alu = rs ^ rt;
            6'h27: e_alu = ~(rs | rt);
            6'h00: e_alu = rt << sh;
            6'h02: e_alu = rt >> sh;
            6'h03: e_alu = $signed(rt) >>> sh;
            6'h2A: e_alu = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
            6'h2B: e_alu = (rs < rt) ? 32'd1 : 32'd0;
            6'h08: begin e_pc = 3'd3; e_rw = 1'b0; e_aluv = 1'b0; end
            6'h09: begin e_pc = 3'd3; e_mtr = 2'd2; e_aluv = 1'b0; end
            default: known = 1'b0;
         endcase
      end else begin
         case (op)
            6'h23: begin e_alu = rs + se; e_rw = 1'b1; e_rd = 2'd1; e_mtr = 2'd1; e_ld = 1'b1; end
            6'h2B: begin e_alu = rs + se; e_st = 1'b1; end
            6'h0F: begin e_alu = {ins[15:0], 16'h0}; e_rw = 1'b1; e_rd = 2'd1; end
            6'h08, 6'h09: begin e_alu = rs + se; e_rw = 1'b1; e_rd = 2'd1; end
            6'h0C: begin e_alu = rs & ze; e_rw = 1'b1; e_rd = 2'd1; end
            6'h0A: begin e_alu = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; e_rw = 1'b1; e_rd = 2'd1; end
            6'h0B: begin e_alu = (rs < se) ? 32'd1 : 32'd0; e_rw = 1'b1; e_rd = 2'd1; end
            6'h04: begin e_pc = 3'd1; e_alu = (rs == rt) ? 32'd1 : 32'd0; end
            6'h05: begin e_pc = 3'd1; e_alu = (rs != rt) ? 32'd1 : 32'd0; end
            6'h06: begin e_pc = 3'd1; e_alu = ($signed(rs) <= 0) ? 32'd1 : 32'd0; end
            6'h07: begin e_pc = 3'd1; e_alu = ($signed(rs) > 0) ? 32'd1 : 32'd0; end
            6'h01: begin e_pc = 3'd1; e_alu = ($signed(rs) < 0) ? 32'd1 : 32'd0; end
            6'h02: begin e_pc = 3'd2; e_aluv = 1'b0; end
            6'h03: begin e_pc = 3'd2; e_rw = 1'b1; e_rd = 2'd2; e_mtr = 2'd2; e_aluv = 1'b0; end
            default: known = 1'b0;
         endcase
      end
      if (iq && !pk || !known) begin
         e_pc = (iq && !pk) ? 3'd4 : 3'd5;
         e_rw = 1'b1; e_rd = 2'd3; e_mtr = 2'd2;
         e_aluv = 1'b0; e_ld = 1'b0; e_st = 1'b0;
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic pk, input logic iq);
      logic [31:0] e_rdata;
      @(negedge clk);
      instr = ins; rs_data = a; rt_data = b; pck = pk; irq = iq;
      #1;
      model(ins, a, b, pk, iq);
      e_rdata = (e_ld && !e_alu[30]) ? ref_mem[e_alu[9:2]] : 32'h0;
      chk("pcsrc", 32'(pcsrc), 32'(e_pc));
      chk("regdst", 32'(regdst), 32'(e_rd));
      chk("memtoreg", 32'(memtoreg), 32'(e_mtr));
      chk("regwrite", 32'(regwrite), 32'(e_rw));
      if (e_aluv) begin
         chk("alu_out", alu_out, e_alu);
         chk("branch_tkn", 32'(branch_tkn), 32'(e_alu[0]));
      end
      chk("mem_rd", 32'(mem_rd), 32'(e_ld && e_alu[30]));
      chk("mem_wr", 32'(mem_wr), 32'(e_st && e_alu[30]));
      chk("mem_rdata", mem_rdata, e_rdata);
      if (e_st && !e_alu[30] && reset) ref_mem[e_alu[9:2]] = b;
   endtask

   initial begin
      logic [31:0] ins, a, b;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      #12 reset = 1'b1;
      step(it_i(6'h23, 16'h0010), 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset_rdata", mem_rdata, 32'h0);
      step(it_i(6'h08, 16'hFFFF), 32'd5, 32'd0, 1'b0, 1'b0);
      chk("addi_alu", alu_out, 32'd4);
      chk("addi_regdst", 32'(regdst), 32'd1);
      chk("addi_regwrite", 32'(regwrite), 32'd1);
      step(rt_i(6'h22, 5'd0), 32'd3, 32'd5, 1'b0, 1'b0);
      chk("sub_alu", alu_out, 32'hFFFFFFFE);
      step(it_i(6'h2B, 16'h0010), 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      step(it_i(6'h23, 16'h0010), 32'h0, 32'h0, 1'b0, 1'b0);
      chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
      chk("lw_memtoreg", 32'(memtoreg), 32'd1);
      step(it_i(6'h2B, 16'h0010), 32'h40000000, 32'h11111111, 1'b0, 1'b0);
      chk("periph_mem_wr", 32'(mem_wr), 32'd1);
      step(it_i(6'h23, 16'h0010), 32'h0, 32'h0, 1'b0, 1'b0);
      chk("ram_unchanged", mem_rdata, 32'hDEADBEEF);
      step(it_i(6'h23, 16'h0010), 32'h40000000, 32'h0, 1'b0, 1'b0);
      chk("periph_mem_rd", 32'(mem_rd), 32'd1);
      step(it_i(6'h04, 16'h0004), 32'd7, 32'd7, 1'b0, 1'b0);
      chk("beq_pcsrc", 32'(pcsrc), 32'd1);
      chk("beq_tkn", 32'(branch_tkn), 32'd1);
      step(it_i(6'h05, 16'h0004), 32'd7, 32'd7, 1'b0, 1'b0);
      chk("bne_tkn", 32'(branch_tkn), 32'd0);
      step(it_i(6'h01, 16'h0004), 32'h80000000, 32'd0, 1'b0, 1'b0);
      chk("bltz_tkn", 32'(branch_tkn), 32'd1);
      step(rt_i(6'h00, 5'd4), 32'd0, 32'd1, 1'b0, 1'b0);
      chk("sll", alu_out, 32'h10);
      step(rt_i(6'h03, 5'd4), 32'd0, 32'h80000000, 1'b0, 1'b0);
      chk("sra", alu_out, 32'hF8000000);
      step(rt_i(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
      chk("slt", alu_out, 32'd1);
      step(rt_i(6'h2B, 5'd0), 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
      chk("sltu", alu_out, 32'd0);
      step(rt_i(6'h20, 5'd0), 32'd2, 32'd3, 1'b0, 1'b1);
      chk("irq_pcsrc", 32'(pcsrc), 32'd4);
      chk("irq_regdst", 32'(regdst), 32'd3);
      chk("irq_memtoreg", 32'(memtoreg), 32'd2);
      step(rt_i(6'h20, 5'd0), 32'd2, 32'd3, 1'b1, 1'b1);
      chk("masked_pcsrc", 32'(pcsrc), 32'd0);
      chk("masked_alu", alu_out, 32'd5);
      step(it_i(6'h3F, 16'h0), 32'd2, 32'd3, 1'b0, 1'b0);
      chk("exc_pcsrc", 32'(pcsrc), 32'd5);
      step(it_i(6'h2B, 16'h0020), 32'h0, 32'h12345678, 1'b0, 1'b0);
      step(it_i(6'h23, 16'h0020), 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      step(it_i(6'h23, 16'h0020), 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset_clears", mem_rdata, 32'h0);
      step(it_i(6'h2B, 16'h0020), 32'h0, 32'hAAAA5555, 1'b0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      step(it_i(6'h23, 16'h0020), 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset_blocks_wr", mem_rdata, 32'h0);
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: ins = rt_i(r_fns[$urandom_range(0, 14)], 5'($urandom));
            4, 5, 6, 7: ins = it_i(i_ops[$urandom_range(0, 14)], 16'($urandom));
            default: ;
         endcase
         if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
            ins[15:0] = 16'($urandom_range(0, 15) * 4);
            a = ($urandom & 32'h000000FC) | (($urandom_range(0, 3) == 0) ? 32'h40000000 : 32'h0);
         end
         if ($urandom_range(0, 3) == 0) b = a;
         step(ins, a, b, 1'($urandom), $urandom_range(0, 9) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
